// File: rtl/cdb_writeback_arbiter_if.sv
// Bus bundle between the functional-unit result sources and the writeback arbiter.
// It carries the per-source result offers, the flush, and the registered CDB/ROB update ports.
interface cdb_writeback_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int NUM_CDB = 2,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6
);
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_regwr;
    logic [NUM_SRC-1:0]        src_pred;
    logic [NUM_SRC-1:0]        src_taken;
    logic                      flush;

    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_value;
    logic [NUM_CDB-1:0]        rob_wr_valid;
    logic [NUM_CDB*TAG_W-1:0]  rob_wr_tag;
    logic [NUM_CDB*DATA_W-1:0] rob_wr_value;
    logic [NUM_CDB-1:0]        rob_wr_regwr;
    logic [NUM_CDB-1:0]        rob_wr_mispredict;

    // Result producers and the consumers of the CDB/ROB update.
    modport master (
        output src_valid, src_tag, src_data, src_regwr, src_pred, src_taken, flush,
        input  src_ready,
        input  cdb_valid, cdb_tag, cdb_value,
        input  rob_wr_valid, rob_wr_tag, rob_wr_value, rob_wr_regwr, rob_wr_mispredict
    );

    // The writeback arbiter itself.
    modport slave (
        input  src_valid, src_tag, src_data, src_regwr, src_pred, src_taken, flush,
        output src_ready,
        output cdb_valid, cdb_tag, cdb_value,
        output rob_wr_valid, rob_wr_tag, rob_wr_value, rob_wr_regwr, rob_wr_mispredict
    );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// Writeback stage: one FIFO per functional-unit source, round-robin pick of up to NUM_CDB
// heads per cycle, and registered CDB broadcast plus ROB ready/value/mispredict update.
// A mispredict is only reported to the ROB; squashing is left to the ROB/flush logic.
module cdb_writeback_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int NUM_CDB    = 2,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    cdb_writeback_arbiter_if.slave bus
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_W-1:0]  mem_tag   [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data  [NUM_SRC][FIFO_DEPTH];
    logic              mem_regwr [NUM_SRC][FIFO_DEPTH];
    logic              mem_mis   [NUM_SRC][FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr [NUM_SRC];
    logic [PTR_W-1:0]  rd_ptr [NUM_SRC];
    logic [CNT_W-1:0]  count  [NUM_SRC];

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] ready;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] grant;

    logic [TAG_W-1:0]  head_tag   [NUM_SRC];
    logic [DATA_W-1:0] head_data  [NUM_SRC];
    logic              head_regwr [NUM_SRC];
    logic              head_mis   [NUM_SRC];

    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   rr_next;
    logic [NUM_CDB-1:0] port_vld;
    logic [SRC_W-1:0]   port_src [NUM_CDB];

    logic [TAG_W-1:0]  sel_tag   [NUM_CDB];
    logic [DATA_W-1:0] sel_data  [NUM_CDB];
    logic              sel_regwr [NUM_CDB];
    logic              sel_mis   [NUM_CDB];

    logic [NUM_CDB-1:0]        cdb_valid_q;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag_q;
    logic [NUM_CDB*DATA_W-1:0] cdb_value_q;
    logic [NUM_CDB-1:0]        rob_valid_q;
    logic [NUM_CDB*TAG_W-1:0]  rob_tag_q;
    logic [NUM_CDB*DATA_W-1:0] rob_value_q;
    logic [NUM_CDB-1:0]        rob_regwr_q;
    logic [NUM_CDB-1:0]        rob_mis_q;

    // FIFO status and accept: full uses the pre-pop count so a full FIFO never takes a push;
    // tag 0 means "no ROB entry", so such an offer is acknowledged but dropped.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            full[s]  = (count[s] == CNT_W'(FIFO_DEPTH));
            empty[s] = (count[s] == '0);
            ready[s] = !full[s] && !reset && !bus.flush;
            push[s]  = bus.src_valid[s] && ready[s] && (bus.src_tag[s*TAG_W +: TAG_W] != '0);
        end
    end

    assign bus.src_ready = ready;

    // Head-of-FIFO view for every source.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            head_tag[s]   = mem_tag[s][rd_ptr[s]];
            head_data[s]  = mem_data[s][rd_ptr[s]];
            head_regwr[s] = mem_regwr[s][rd_ptr[s]];
            head_mis[s]   = mem_mis[s][rd_ptr[s]];
        end
    end

    // Round-robin scan from rr_ptr: the first NUM_CDB non-empty sources land on ports 0,1,...
    always_comb begin
        int               n_gr;
        logic [SRC_W-1:0] last_g;
        n_gr   = 0;
        last_g = rr_ptr;
        grant    = '0;
        port_vld = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            port_src[k] = '0;
        end
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if ((s == (int'(rr_ptr) + j) % NUM_SRC) && !empty[s] && !bus.flush
                    && (n_gr < NUM_CDB)) begin
                    grant[s] = 1'b1;
                    for (int k = 0; k < NUM_CDB; k++) begin
                        if (k == n_gr) begin
                            port_vld[k] = 1'b1;
                            port_src[k] = SRC_W'(s);
                        end
                    end
                    last_g = SRC_W'(s);
                    n_gr++;
                end
            end
        end
        rr_next = (n_gr == 0) ? rr_ptr : SRC_W'((int'(last_g) + 1) % NUM_SRC);
    end

    // Per-port mux of the granted head; ungranted ports carry all-zero fields.
    always_comb begin
        for (int k = 0; k < NUM_CDB; k++) begin
            sel_tag[k]   = '0;
            sel_data[k]  = '0;
            sel_regwr[k] = 1'b0;
            sel_mis[k]   = 1'b0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (port_vld[k] && (port_src[k] == SRC_W'(s))) begin
                    sel_tag[k]   = head_tag[s];
                    sel_data[k]  = head_data[s];
                    sel_regwr[k] = head_regwr[s];
                    sel_mis[k]   = head_mis[s];
                end
            end
        end
    end

    // FIFO pointer/count bookkeeping; flush drops everything buffered.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
                count[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (push[s]) begin
                    wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
                end
                if (grant[s]) begin
                    rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
                end
                count[s] <= count[s] + CNT_W'(push[s]) - CNT_W'(grant[s]);
            end
        end
    end

    // FIFO storage; the mispredict flag is resolved once, at push time.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (push[s]) begin
                mem_tag[s][wr_ptr[s]]   <= bus.src_tag[s*TAG_W +: TAG_W];
                mem_data[s][wr_ptr[s]]  <= bus.src_data[s*DATA_W +: DATA_W];
                mem_regwr[s][wr_ptr[s]] <= bus.src_regwr[s];
                mem_mis[s][wr_ptr[s]]   <= bus.src_pred[s] ^ bus.src_taken[s];
            end
        end
    end

    // Registered CDB/ROB outputs and round-robin pointer (held when nothing is granted).
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            cdb_valid_q <= '0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            rob_valid_q <= '0;
            rob_tag_q   <= '0;
            rob_value_q <= '0;
            rob_regwr_q <= '0;
            rob_mis_q   <= '0;
        end else begin
            rr_ptr <= rr_next;
            for (int k = 0; k < NUM_CDB; k++) begin
                rob_valid_q[k]                  <= port_vld[k];
                rob_tag_q[k*TAG_W +: TAG_W]     <= sel_tag[k];
                rob_value_q[k*DATA_W +: DATA_W] <= sel_data[k];
                rob_regwr_q[k]                  <= sel_regwr[k];
                rob_mis_q[k]                    <= sel_mis[k];
                cdb_valid_q[k]                  <= sel_regwr[k];
                cdb_tag_q[k*TAG_W +: TAG_W]     <= sel_regwr[k] ? sel_tag[k] : '0;
                cdb_value_q[k*DATA_W +: DATA_W] <= sel_regwr[k] ? sel_data[k] : '0;
            end
        end
    end

    assign bus.cdb_valid         = cdb_valid_q;
    assign bus.cdb_tag           = cdb_tag_q;
    assign bus.cdb_value         = cdb_value_q;
    assign bus.rob_wr_valid      = rob_valid_q;
    assign bus.rob_wr_tag        = rob_tag_q;
    assign bus.rob_wr_value      = rob_value_q;
    assign bus.rob_wr_regwr      = rob_regwr_q;
    assign bus.rob_wr_mispredict = rob_mis_q;
endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Directed bench for cdb_writeback_arbiter: vector table of single-cycle offers from reset,
// plus hand-written sequences for reset, a full-rate stream and flush.
module tb_cdb_writeback_arbiter;
    localparam int NS = 4;
    localparam int NC = 2;
    localparam int DW = 32;
    localparam int TW = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    cdb_writeback_arbiter_if #(.NUM_SRC(NS), .NUM_CDB(NC), .DATA_W(DW), .TAG_W(TW)) bus ();

    cdb_writeback_arbiter #(
        .NUM_SRC(NS), .NUM_CDB(NC), .DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [NS-1:0]               valid;
        logic [NS-1:0][TW-1:0]       tag;
        logic [NS-1:0]               regwr;
        logic [NS-1:0]               pred;
        logic [NS-1:0]               taken;
        logic [1:0][NC-1:0][TW-1:0]  e_tag;   // [out cycle][port], 0 = port idle
        logic [1:0][NC-1:0]          e_cdb;
        logic [1:0][NC-1:0]          e_mis;
    } vec_t;

    vec_t vecs[5];

    typedef struct {
        int tag;
        int cyc;
    } ent_t;

    ent_t q[NS][$];

    function automatic logic [31:0] dat(input logic [TW-1:0] t);
        return 32'hC0DE_0000 | 32'(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.src_valid = '0;
        bus.src_tag   = '0;
        bus.src_data  = '0;
        bus.src_regwr = '0;
        bus.src_pred  = '0;
        bus.src_taken = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic drive_src(input int s, input logic [TW-1:0] t, input logic [DW-1:0] d,
                             input logic rw, input logic pr, input logic tk);
        bus.src_valid[s]         = 1'b1;
        bus.src_tag[s*TW +: TW]  = t;
        bus.src_data[s*DW +: DW] = d;
        bus.src_regwr[s]         = rw;
        bus.src_pred[s]          = pr;
        bus.src_taken[s]         = tk;
    endtask

    task automatic check_port(input string nm, input int k, input logic [TW-1:0] et,
                              input logic ec, input logic em, input logic [DW-1:0] ed);
        chk({nm, "/rob_valid"}, 64'(bus.rob_wr_valid[k]), 64'(et != '0));
        chk({nm, "/rob_tag"},   64'(bus.rob_wr_tag[k*TW +: TW]), 64'(et));
        chk({nm, "/rob_value"}, 64'(bus.rob_wr_value[k*DW +: DW]), 64'(ed));
        chk({nm, "/rob_regwr"}, 64'(bus.rob_wr_regwr[k]), 64'(ec));
        chk({nm, "/rob_mis"},   64'(bus.rob_wr_mispredict[k]), 64'(em));
        chk({nm, "/cdb_valid"}, 64'(bus.cdb_valid[k]), 64'(ec));
        chk({nm, "/cdb_tag"},   64'(bus.cdb_tag[k*TW +: TW]), ec ? 64'(et) : 64'd0);
        chk({nm, "/cdb_value"}, 64'(bus.cdb_value[k*DW +: DW]), ec ? 64'(ed) : 64'd0);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "/cdb_valid"},  64'(bus.cdb_valid), 64'd0);
        chk({nm, "/cdb_tag"},    64'(bus.cdb_tag), 64'd0);
        chk({nm, "/cdb_value"},  64'(bus.cdb_value), 64'd0);
        chk({nm, "/rob_valid"},  64'(bus.rob_wr_valid), 64'd0);
        chk({nm, "/rob_tag"},    64'(bus.rob_wr_tag), 64'd0);
        chk({nm, "/rob_value"},  64'(bus.rob_wr_value), 64'd0);
        chk({nm, "/rob_regwr"},  64'(bus.rob_wr_regwr), 64'd0);
        chk({nm, "/rob_mis"},    64'(bus.rob_wr_mispredict), 64'd0);
    endtask

    task automatic do_reset(input bit check);
        @(posedge clk); #1;
        reset = 1'b1;
        set_idle();
        @(posedge clk);
        @(negedge clk);
        if (check) begin
            check_zero("reset");
            chk("reset/src_ready", 64'(bus.src_ready), 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        if (check) begin
            chk("post_reset/src_ready", 64'(bus.src_ready), 64'hF);
            check_zero("post_reset");
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t;
        int         sidx;
        int         max_wait;
        int         wait_c[NS];
        bit         saw_full;
        logic [NS-1:0] seen;

        set_idle();

        // vector table: single-cycle offers from a fresh reset (rr_ptr = 0)
        for (int i = 0; i < 5; i++) vecs[i] = '{default: '0};
        // lone regwr result on src0
        vecs[0].valid = 4'b0001; vecs[0].tag[0] = 6'd5; vecs[0].regwr = 4'b0001;
        vecs[0].e_tag[0][0] = 6'd5; vecs[0].e_cdb[0] = 2'b01;
        // all four at once: (1,2) then (3,4)
        vecs[1].valid = 4'b1111; vecs[1].regwr = 4'b1111;
        vecs[1].tag[0] = 6'd1; vecs[1].tag[1] = 6'd2; vecs[1].tag[2] = 6'd3; vecs[1].tag[3] = 6'd4;
        vecs[1].e_tag[0][0] = 6'd1; vecs[1].e_tag[0][1] = 6'd2; vecs[1].e_cdb[0] = 2'b11;
        vecs[1].e_tag[1][0] = 6'd3; vecs[1].e_tag[1][1] = 6'd4; vecs[1].e_cdb[1] = 2'b11;
        // mispredicted branch without regwr on src3; tag-0 offer on src1 is dropped
        vecs[2].valid = 4'b1010; vecs[2].tag[3] = 6'd9; vecs[2].tag[1] = 6'd0;
        vecs[2].regwr = 4'b0010; vecs[2].pred = 4'b1000; vecs[2].taken = 4'b0000;
        vecs[2].e_tag[0][0] = 6'd9; vecs[2].e_mis[0] = 2'b01;
        // two branches: src1 predicted right, src3 wrong
        vecs[3].valid = 4'b1010; vecs[3].tag[1] = 6'd10; vecs[3].tag[3] = 6'd11;
        vecs[3].regwr = 4'b1010; vecs[3].pred = 4'b0010; vecs[3].taken = 4'b1010;
        vecs[3].e_tag[0][0] = 6'd10; vecs[3].e_tag[0][1] = 6'd11;
        vecs[3].e_cdb[0] = 2'b11; vecs[3].e_mis[0] = 2'b10;
        // three sources: 0,2 first (src0 no regwr), src3 next cycle
        vecs[4].valid = 4'b1101; vecs[4].tag[0] = 6'd22; vecs[4].tag[2] = 6'd20;
        vecs[4].tag[3] = 6'd21; vecs[4].regwr = 4'b1100;
        vecs[4].e_tag[0][0] = 6'd22; vecs[4].e_tag[0][1] = 6'd20; vecs[4].e_cdb[0] = 2'b10;
        vecs[4].e_tag[1][0] = 6'd21; vecs[4].e_cdb[1] = 2'b01;

        // reset behaviour
        do_reset(1'b1);

        // single regwr result, two-cycle latency
        @(posedge clk); #1;
        drive_src(0, 6'd5, 32'hDEAD, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check_zero("dead/t+1");
        @(posedge clk);
        @(negedge clk);
        check_port("dead/p0", 0, 6'd5, 1'b1, 1'b0, 32'hDEAD);
        check_port("dead/p1", 1, 6'd0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 5; i++) begin
            do_reset(1'b0);
            @(posedge clk); #1;
            for (int s = 0; s < NS; s++) begin
                if (vecs[i].valid[s])
                    drive_src(s, vecs[i].tag[s], dat(vecs[i].tag[s]), vecs[i].regwr[s],
                              vecs[i].pred[s], vecs[i].taken[s]);
            end
            @(posedge clk); #1;
            set_idle();
            for (int c = 0; c < 2; c++) begin
                @(posedge clk);
                @(negedge clk);
                for (int k = 0; k < NC; k++) begin
                    check_port($sformatf("vec%0d/c%0d/p%0d", i, c, k), k, vecs[i].e_tag[c][k],
                               vecs[i].e_cdb[c][k], vecs[i].e_mis[c][k],
                               (vecs[i].e_tag[c][k] != '0) ? dat(vecs[i].e_tag[c][k]) : 32'h0);
                end
            end
        end

        // full-rate stream: every source offers every cycle for 10 cycles
        do_reset(1'b0);
        max_wait = 0;
        saw_full = 1'b0;
        for (int s = 0; s < NS; s++) wait_c[s] = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            set_idle();
            if (c < 10) begin
                for (int s = 0; s < NS; s++)
                    drive_src(s, 6'(1 + 4 * c + s), dat(6'(1 + 4 * c + s)), 1'b1, 1'b0, 1'b0);
            end
            @(negedge clk);
            seen = '0;
            for (int k = 0; k < NC; k++) begin
                if (bus.rob_wr_valid[k]) begin
                    t = int'(bus.rob_wr_tag[k*TW +: TW]);
                    if (t < 1) begin
                        tests++; fails++;
                        $display("FAIL stream/tag0: got tag 0 on port %0d, expected nonzero", k);
                    end else begin
                        sidx = (t - 1) % NS;
                        if (q[sidx].size() == 0) begin
                            tests++; fails++;
                            $display("FAIL stream/dup: got tag %0d, expected none pending", t);
                        end else begin
                            chk("stream/order", 64'(t), 64'(q[sidx][0].tag));
                            void'(q[sidx].pop_front());
                            seen[sidx] = 1'b1;
                        end
                    end
                end
            end
            for (int s = 0; s < NS; s++) begin
                if (seen[s]) wait_c[s] = 0;
                else if (q[s].size() > 0 && q[s][0].cyc + 2 <= c) begin
                    wait_c[s]++;
                    if (wait_c[s] > max_wait) max_wait = wait_c[s];
                end
                if (bus.src_valid[s] && !bus.src_ready[s]) saw_full = 1'b1;
                if (bus.src_valid[s] && bus.src_ready[s])
                    q[s].push_back('{tag: int'(bus.src_tag[s*TW +: TW]), cyc: c});
            end
        end
        chk("stream/ready_fell", 64'(saw_full), 64'd1);
        chk("stream/fairness", 64'(max_wait <= 2), 64'd1);
        for (int s = 0; s < NS; s++)
            chk($sformatf("stream/drained%0d", s), 64'(q[s].size()), 64'd0);

        // flush with three buffered entries and a concurrent push
        do_reset(1'b0);
        @(posedge clk); #1;
        drive_src(0, 6'd30, dat(6'd30), 1'b1, 1'b0, 1'b0);
        drive_src(1, 6'd31, dat(6'd31), 1'b1, 1'b0, 1'b0);
        drive_src(2, 6'd32, dat(6'd32), 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_idle();
        bus.flush = 1'b1;
        drive_src(3, 6'd7, dat(6'd7), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("flush/src_ready", 64'(bus.src_ready), 64'd0);
        check_zero("flush/t");
        @(posedge clk); #1;
        set_idle();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check_zero($sformatf("flush/t+%0d", c));
            @(posedge clk); #1;
        end

        // after flush the FIFOs accept and deliver fresh results again
        drive_src(1, 6'd12, dat(6'd12), 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_idle();
        @(posedge clk);
        @(negedge clk);
        check_port("post_flush/p0", 0, 6'd12, 1'b1, 1'b0, dat(6'd12));
        check_port("post_flush/p1", 1, 6'd0, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
